mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Parametrised N-input, W-bit registered channel selector with per-channel valid/ready handshake.
- Two selection modes:
  - explicit: a select input picks the source channel;
  - round-robin: the block arbitrates fairly among valid channels.
- A single-entry output register gives 1-cycle latency and full throughput.
- Sits between multiple producer lanes and one consumer lane.
- Replaces fixed-width combinational case-style muxes wherever backpressure or arbitration is needed.

Parameters:
- W, 4, data width per channel (≥1).
- N, 4, number of input channels (≥2; need not be a power of two).
- SELW, $clog2(N), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SELW  source channel in explicit mode; ignored in round-robin.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept (one-hot or zero).
- out_valid  output  1  output register holds data.
- out_data  output  W  registered data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.
- err  output  1  sticky flag: explicit sel ≥ N was presented.
- err_clr  input  1  clears err.

Behaviour:
- Reset (rstn low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0, err=0.
  - Buffered data is discarded.
  - in_ready is 0 while in reset.
- can_accept = !out_valid || out_ready (combinational).
- Grant selection (combinational, one grant per cycle):
  - explicit mode: grant = sel if sel < N and in_valid[sel]; otherwise no grant.
  - round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap at N, not 2^SELW). No grant if in_valid == 0.
- in_ready[i] = can_accept && grant valid && grant == i. in_ready never depends on in_valid[i] of other channels beyond the grant choice.
- Transfer (in_valid[g] && in_ready[g]) at edge:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - Latency: 1 cycle from accepted input to out_valid.
- Output drain: out_valid && out_ready with no new transfer -> out_valid <= 0.
  - out_data and out_ch hold their last values.
- Simultaneous drain and transfer: out_valid stays 1 and new data loads; this gives full throughput of one word per cycle.
- Stall: out_valid && !out_ready -> out_data and out_ch are stable, all in_ready=0.
- ptr update:
  - Only on a transfer in round-robin mode: ptr <= (g == N-1) ? 0 : g+1.
  - Explicit-mode transfers leave ptr unchanged.
- err:
  - Set when mode==0 && sel ≥ N on any cycle, regardless of can_accept.
  - Cleared by err_clr.
  - Set and clear in the same cycle: set wins.
  - When N is a power of two, err is constant 0.
- Mode change takes effect on the next grant decision; any word already in the output register is unaffected.
- Reset asserted mid-transfer: the word is lost and no partial state remains. On rstn release, the first round-robin grant searches from channel 0.
- No combinational path from out_ready to out_data/out_valid. The only combinational path from out_ready is to in_ready.

Test Plan:
- Reset: hold rstn=0 with all in_valid=1111, out_ready=1 -> out_valid=0, out_data=0, in_ready=0000, err=0. Release rstn: first grant in round-robin is ch0.
- Explicit mux (N=4, W=4): mode=0; in_data ch0..3 = 0x1,0x2,0x3,0x4; all valid; out_ready=1; sel sweeps 0,1,2,3 -> out_data 0x1,0x2,0x3,0x4 each one cycle after its sel, with out_ch matching sel.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=1010 -> sequence 1,3,1,3.
- Backpressure: one word accepted, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000, ptr unchanged. Raise out_ready with ch2 valid -> drain and load in the same edge, out_valid stays 1.
- Out-of-range select (N=3): mode=0, sel=3, in_valid=111 -> no transfer, in_ready=000, err=1 next cycle and stays 1 after sel=0. err_clr=1 with sel=3 held -> err remains 1. err_clr with sel=0 -> err=0.
- Mode switch mid-stream: round-robin grants ch1 (ptr=2), switch to mode=0 with sel=0 -> next out_ch=0. Switch back to mode=1 -> next grant searches from ch2.

Source files
------------

// File: rtl/mux_arb_reg_if.sv
// Bus bundle for mux_arb_reg: producer lanes, consumer lane, select and error flag.
interface mux_arb_reg_if #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_ready;
    logic              err;
    logic              err_clr;

    // Driving side (producers, consumer and control).
    modport master (
        output mode, sel, in_valid, in_data, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_ch, err
    );

    // Selector side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_ch, err
    );
endinterface

// File: rtl/mux_arb_reg.sv
// N-input registered channel selector with explicit or round-robin grant
// and a single-entry output register (1-cycle latency, full throughput).
module mux_arb_reg #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    mux_arb_reg_if.slave bus
);
    localparam int unsigned SELW = $clog2(N);

    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic [SELW-1:0]   out_ch_q;
    logic [SELW-1:0]   ptr;
    logic              err_q;

    logic              can_accept;
    logic              gnt_vld;
    logic [SELW-1:0]   gnt;
    logic              hi_vld;
    logic [SELW-1:0]   hi;
    logic              lo_vld;
    logic [SELW-1:0]   lo;
    logic [W-1:0]      gnt_data;
    logic [N-1:0]      in_ready_c;
    logic              xfer;
    logic              err_set;

    assign can_accept = !out_valid_q || bus.out_ready;
    assign err_set    = !bus.mode && (32'(bus.sel) >= N);

    // Grant choice: explicit select, or first valid channel at/after ptr with wrap at N.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        hi_vld  = 1'b0;
        hi      = '0;
        lo_vld  = 1'b0;
        lo      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.in_valid[i]) begin
                if (i >= 32'(ptr)) begin
                    if (!hi_vld) begin
                        hi_vld = 1'b1;
                        hi     = SELW'(i);
                    end
                end else if (!lo_vld) begin
                    lo_vld = 1'b1;
                    lo     = SELW'(i);
                end
            end
        end
        if (bus.mode) begin
            gnt_vld = hi_vld || lo_vld;
            gnt     = hi_vld ? hi : lo;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(bus.sel) == i && bus.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end
    end

    // Granted channel's data and the one-hot accept vector.
    always_comb begin
        gnt_data   = '0;
        in_ready_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = bus.in_data[i*W +: W];
            end
            in_ready_c[i] = rstn && can_accept && gnt_vld && (gnt == SELW'(i));
        end
    end

    assign xfer = |(in_ready_c & bus.in_valid);

    // Output register, round-robin pointer and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
            err_q       <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_ch_q    <= gnt;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (xfer && bus.mode) begin
                ptr <= (32'(gnt) == N - 1) ? '0 : gnt + SELW'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: N=4 instance for mux/arbitration, N=3 for select range.
module tb_mux_arb_reg;
    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total;

    mux_arb_reg_if #(.W(4), .N(4)) b4 ();
    mux_arb_reg_if #(.W(4), .N(3)) b3 ();

    mux_arb_reg #(.W(4), .N(4)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));
    mux_arb_reg #(.W(4), .N(3)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        b4.mode = 1'b0; b4.sel = '0; b4.in_valid = '0; b4.in_data = 16'h4321;
        b4.out_ready = 1'b0; b4.err_clr = 1'b0;
        b3.mode = 1'b0; b3.sel = '0; b3.in_valid = '0; b3.in_data = 12'h321;
        b3.out_ready = 1'b0; b3.err_clr = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        tick();
        tick();
        total++; if (b4.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", b4.out_valid); else pass_cnt++;
        total++; if (b4.out_data !== 4'h0) $display("FAIL rst_out_data got %h want 0", b4.out_data); else pass_cnt++;
        total++; if (b4.out_ch !== 2'd0) $display("FAIL rst_out_ch got %0d want 0", b4.out_ch); else pass_cnt++;
        total++; if (b4.in_ready !== 4'b0000) $display("FAIL rst_in_ready got %b want 0000", b4.in_ready); else pass_cnt++;
        total++; if (b4.err !== 1'b0) $display("FAIL rst_err got %b want 0", b4.err); else pass_cnt++;
        rstn = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b0001) $display("FAIL rst_first_grant in_ready got %b want 0001", b4.in_ready); else pass_cnt++;
        tick();
        total++; if (b4.out_valid !== 1'b1 || b4.out_ch !== 2'd0 || b4.out_data !== 4'h1)
            $display("FAIL rst_first_word got v=%b ch=%0d d=%h want v=1 ch=0 d=1", b4.out_valid, b4.out_ch, b4.out_data);
        else pass_cnt++;
    endtask

    task automatic test_explicit();
        logic [3:0] exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_dat [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        b4.mode = 1'b0; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b4.sel = 2'(s);
            #1;
            total++; if (b4.in_ready !== exp_rdy[s]) $display("FAIL expl_in_ready sel=%0d got %b want %b", s, b4.in_ready, exp_rdy[s]); else pass_cnt++;
            tick();
            total++; if (b4.out_valid !== 1'b1 || b4.out_data !== exp_dat[s] || b4.out_ch !== 2'(s))
                $display("FAIL expl_out sel=%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d", s, b4.out_valid, b4.out_data, b4.out_ch, exp_dat[s], s);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq_all [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] seq_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [3:0] dat_all [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (b4.out_ch !== seq_all[k] || b4.out_data !== dat_all[k] || b4.out_valid !== 1'b1)
                $display("FAIL rr_all step=%0d got ch=%0d d=%h v=%b want ch=%0d d=%h v=1", k, b4.out_ch, b4.out_data, b4.out_valid, seq_all[k], dat_all[k]);
            else pass_cnt++;
        end
        b4.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (b4.out_ch !== seq_odd[k]) $display("FAIL rr_1010 step=%0d got ch=%0d want %0d", k, b4.out_ch, seq_odd[k]); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        b4.mode = 1'b1; b4.in_valid = 4'b0001; b4.out_ready = 1'b1;
        tick();
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== 4'h1 || b4.out_ch !== 2'd0)
            $display("FAIL bp_first got v=%b d=%h ch=%0d want v=1 d=1 ch=0", b4.out_valid, b4.out_data, b4.out_ch);
        else pass_cnt++;
        b4.out_ready = 1'b0; b4.in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (b4.in_ready !== 4'b0000) $display("FAIL bp_stall_ready cyc=%0d got %b want 0000", k, b4.in_ready); else pass_cnt++;
            tick();
            total++; if (b4.out_valid !== 1'b1 || b4.out_data !== 4'h1 || b4.out_ch !== 2'd0)
                $display("FAIL bp_stall_hold cyc=%0d got v=%b d=%h ch=%0d want v=1 d=1 ch=0", k, b4.out_valid, b4.out_data, b4.out_ch);
            else pass_cnt++;
        end
        b4.out_ready = 1'b1;
        #1;
        total++; if (b4.in_ready !== 4'b0100) $display("FAIL bp_release_ready got %b want 0100", b4.in_ready); else pass_cnt++;
        tick();
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== 4'h3 || b4.out_ch !== 2'd2)
            $display("FAIL bp_drain_load got v=%b d=%h ch=%0d want v=1 d=3 ch=2", b4.out_valid, b4.out_data, b4.out_ch);
        else pass_cnt++;
        b4.in_valid = 4'b1111;
        tick();
        total++; if (b4.out_ch !== 2'd3 || b4.out_data !== 4'h4) $display("FAIL bp_ptr_next got ch=%0d d=%h want ch=3 d=4", b4.out_ch, b4.out_data); else pass_cnt++;
        b4.in_valid = 4'b0000;
        tick();
        total++; if (b4.out_valid !== 1'b0 || b4.out_data !== 4'h4 || b4.out_ch !== 2'd3)
            $display("FAIL bp_drain_empty got v=%b d=%h ch=%0d want v=0 d=4 ch=3", b4.out_valid, b4.out_data, b4.out_ch);
        else pass_cnt++;
    endtask

    task automatic test_err_range();
        do_reset();
        b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
        #1;
        total++; if (b3.in_ready !== 3'b000) $display("FAIL err_oor_ready got %b want 000", b3.in_ready); else pass_cnt++;
        total++; if (b3.err !== 1'b0) $display("FAIL err_before got %b want 0", b3.err); else pass_cnt++;
        tick();
        total++; if (b3.err !== 1'b1 || b3.out_valid !== 1'b0) $display("FAIL err_set got err=%b v=%b want err=1 v=0", b3.err, b3.out_valid); else pass_cnt++;
        b3.sel = 2'd0;
        #1;
        total++; if (b3.in_ready !== 3'b001) $display("FAIL err_sel0_ready got %b want 001", b3.in_ready); else pass_cnt++;
        tick();
        total++; if (b3.err !== 1'b1 || b3.out_valid !== 1'b1 || b3.out_ch !== 2'd0 || b3.out_data !== 4'h1)
            $display("FAIL err_sticky got err=%b v=%b ch=%0d d=%h want err=1 v=1 ch=0 d=1", b3.err, b3.out_valid, b3.out_ch, b3.out_data);
        else pass_cnt++;
        b3.sel = 2'd3; b3.err_clr = 1'b1;
        tick();
        total++; if (b3.err !== 1'b1) $display("FAIL err_set_wins got %b want 1", b3.err); else pass_cnt++;
        b3.sel = 2'd0;
        tick();
        total++; if (b3.err !== 1'b0) $display("FAIL err_clr got %b want 0", b3.err); else pass_cnt++;
        b3.err_clr = 1'b0;
        total++; if (b4.err !== 1'b0) $display("FAIL err_pow2_zero got %b want 0", b4.err); else pass_cnt++;
    endtask

    task automatic test_mode_switch();
        do_reset();
        b4.mode = 1'b1; b4.in_valid = 4'b0010; b4.out_ready = 1'b1;
        tick();
        total++; if (b4.out_ch !== 2'd1) $display("FAIL ms_rr_ch1 got %0d want 1", b4.out_ch); else pass_cnt++;
        b4.mode = 1'b0; b4.sel = 2'd0; b4.in_valid = 4'b1111;
        tick();
        total++; if (b4.out_ch !== 2'd0 || b4.out_data !== 4'h1) $display("FAIL ms_expl got ch=%0d d=%h want ch=0 d=1", b4.out_ch, b4.out_data); else pass_cnt++;
        b4.mode = 1'b1;
        tick();
        total++; if (b4.out_ch !== 2'd2 || b4.out_data !== 4'h3) $display("FAIL ms_rr_resume got ch=%0d d=%h want ch=2 d=3", b4.out_ch, b4.out_data); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        rstn     = 1'b0;
        test_reset();
        test_explicit();
        test_round_robin();
        test_backpressure();
        test_err_range();
        test_mode_switch();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
